// File: rtl/serial_add_sub.sv
// Digit-serial two's-complement adder/subtractor with valid/ready handshakes.
// Operands are consumed LSB-first, DIGIT bits per clock; results and flags are registered.
module serial_add_sub #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow,
    output logic             zero
);

    localparam int unsigned N     = WIDTH / DIGIT;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_acc;
    logic               r_cin;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_sum;
    logic               r_carry;
    logic               r_ovf;
    logic               r_zero;

    logic               w_accept;
    logic               w_last;
    logic               w_handshake;
    logic [DIGIT:0]     w_dsum;
    logic               w_c_msb;
    logic               w_ovf;
    logic [WIDTH-1:0]   w_acc_next;

    assign in_ready    = (r_state == ST_IDLE);
    assign out_valid   = (r_state == ST_DONE);
    assign w_accept    = in_valid && in_ready;
    assign w_handshake = out_valid && out_ready;
    assign w_last      = (r_cnt == CNT_W'(N - 1));

    assign sum      = r_sum;
    assign carry    = r_carry;
    assign overflow = r_ovf;
    assign zero     = r_zero;

    // One digit of ripple addition; the top bit of w_dsum is the digit carry-out.
    assign w_dsum  = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]} + (DIGIT+1)'(r_cin);
    // Carry into the digit MSB recovered from the MSB sum bit and its operands.
    assign w_c_msb = r_a[DIGIT-1] ^ r_b[DIGIT-1] ^ w_dsum[DIGIT-1];
    assign w_ovf   = w_c_msb ^ w_dsum[DIGIT];
    assign w_acc_next = (r_acc >> DIGIT) | (WIDTH'(w_dsum[DIGIT-1:0]) << (WIDTH - DIGIT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)    w_next = ST_RUN;
            ST_RUN:  if (w_last)      w_next = ST_DONE;
            ST_DONE: if (w_handshake) w_next = ST_IDLE;
            default:                  w_next = ST_IDLE;
        endcase
    end

    // Operand shift registers, running carry and result/flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_cin   <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
        end else if (w_accept) begin
            r_a   <= a;
            r_b   <= b ^ {WIDTH{sub}};
            r_cin <= sub;
            r_cnt <= '0;
        end else if (r_state == ST_RUN) begin
            r_a   <= r_a >> DIGIT;
            r_b   <= r_b >> DIGIT;
            r_cin <= w_dsum[DIGIT];
            r_cnt <= r_cnt + CNT_W'(1);
            r_acc <= w_acc_next;
            if (w_last) begin
                r_sum   <= w_acc_next;
                r_carry <= w_dsum[DIGIT];
                r_ovf   <= w_ovf;
                r_zero  <= (w_acc_next == '0);
            end
        end
    end

endmodule

// File: tb/tb_serial_add_sub.sv
// Bench for serial_add_sub: three configurations (8/2, 4/1, 16/16) checked every cycle
// against an arithmetic model, plus directed literal vectors.
module tb_serial_add_sub;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  in_valid, in_ready, out_valid, out_ready, carry, overflow, zero;
    logic [15:0] a, b;
    logic        sub;
    logic [7:0]  sum0;
    logic [3:0]  sum1;
    logic [15:0] sum2;
    logic [15:0] sum_w [3];

    localparam int WID  [3] = '{8, 4, 16};
    localparam int NDIG [3] = '{4, 4, 1};

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic [18:0] exp_r    [3];
    bit          pend     [3];
    bit          seen     [3];
    int          acc_edge [3];

    always #5 clk = ~clk;

    assign sum_w[0] = 16'(sum0);
    assign sum_w[1] = 16'(sum1);
    assign sum_w[2] = sum2;

    serial_add_sub #(.WIDTH(8), .DIGIT(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a(a[7:0]), .b(b[7:0]), .sub(sub), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .sum(sum0), .carry(carry[0]), .overflow(overflow[0]), .zero(zero[0])
    );

    serial_add_sub #(.WIDTH(4), .DIGIT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a(a[3:0]), .b(b[3:0]), .sub(sub), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .sum(sum1), .carry(carry[1]), .overflow(overflow[1]), .zero(zero[1])
    );

    serial_add_sub #(.WIDTH(16), .DIGIT(16)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .sum(sum2), .carry(carry[2]), .overflow(overflow[2]), .zero(zero[2])
    );

    // Reference: {zero, overflow, carry, sum} from integer arithmetic on the operand values.
    function automatic logic [18:0] model(input int w, input logic [15:0] aa, input logic [15:0] bb,
                                          input logic s);
        longint mask, ua, ub, sa, sb, res, half;
        logic [15:0] r;
        logic c, o;
        mask = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        ua   = longint'(aa) & mask;
        ub   = longint'(bb) & mask;
        sa   = (ua >= half) ? ua - 2 * half : ua;
        sb   = (ub >= half) ? ub - 2 * half : ub;
        res  = s ? sa - sb : sa + sb;
        o    = (res < -half) || (res >= half);
        c    = s ? (ua >= ub) : ((ua + ub) > mask);
        r    = 16'(res & mask);
        return {r == 16'h0, o, c, r};
    endfunction

    function automatic logic [31:0] res_of(input int i);
        return 32'({zero[i], overflow[i], carry[i], sum_w[i]});
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, expv, cyc);
        end
    endtask

    // Per-cycle scoreboard for all three instances, evaluated at the falling edge.
    task automatic compare_all();
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                pend[i] = 1'b0;
                seen[i] = 1'b0;
                continue;
            end
            check($sformatf("in_ready%0d", i), 32'(in_ready[i]), 32'(!pend[i]));
            if (out_valid[i]) begin
                if (!pend[i]) begin
                    check($sformatf("spurious_valid%0d", i), 32'(out_valid[i]), 32'(pend[i]));
                end else begin
                    if (!seen[i]) begin
                        check($sformatf("latency%0d", i), 32'(cyc - acc_edge[i]), 32'(NDIG[i]));
                        seen[i] = 1'b1;
                    end
                    check($sformatf("result%0d", i), res_of(i), 32'(exp_r[i]));
                end
                if (out_ready[i]) begin
                    pend[i] = 1'b0;
                    seen[i] = 1'b0;
                end
            end else if (pend[i] && (cyc - acc_edge[i] >= NDIG[i])) begin
                check($sformatf("late_valid%0d", i), 32'(out_valid[i]), 32'd1);
                pend[i] = 1'b0;
            end
            if (in_valid[i] && in_ready[i]) begin
                pend[i]     = 1'b1;
                seen[i]     = 1'b0;
                acc_edge[i] = cyc + 1;
                exp_r[i]    = model(WID[i], a, b, sub);
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic wait_valid(input int i);
        int n;
        n = 0;
        while (!out_valid[i] && n < 20) begin
            cycle();
            n++;
        end
        if (!out_valid[i]) check($sformatf("timeout%0d", i), 32'(out_valid[i]), 32'd1);
    endtask

    task automatic run_op(input int i, input logic [15:0] aa, input logic [15:0] bb, input logic s,
                          output logic [31:0] got);
        a = aa; b = bb; sub = s;
        in_valid[i] = 1'b1;
        cycle();
        in_valid[i] = 1'b0;
        wait_valid(i);
        got = res_of(i);
        out_ready[i] = 1'b1;
        cycle();
        out_ready[i] = 1'b0;
    endtask

    initial begin
        logic [31:0] got;
        int ops, guard;
        rst_n = 1'b0; in_valid = '0; out_ready = '0; a = '0; b = '0; sub = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pend[i] = 1'b0; seen[i] = 1'b0; acc_edge[i] = 0; exp_r[i] = '0;
        end
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_result%0d", i), res_of(i), 32'd0);
            check($sformatf("rst_valid%0d", i), 32'(out_valid[i]), 32'd0);
        end
        cycle(); cycle();
        rst_n = 1'b1;
        cycle();
        check("rel_in_ready", 32'(in_ready), 32'h7);

        // Model anchored to hand-computed values.
        check("model_w4_add", 32'(model(4, 16'hA, 16'hB, 1'b0)), 32'h30005);
        check("model_w8_sub", 32'(model(8, 16'h80, 16'h01, 1'b1)), 32'h3007F);

        run_op(1, 16'hA, 16'hB, 1'b0, got);   check("w4_add", got, 32'h30005);
        run_op(1, 16'hA, 16'hB, 1'b1, got);   check("w4_sub", got, 32'h0000F);
        run_op(0, 16'h7F, 16'h01, 1'b0, got); check("w8_7f_plus_1", got, 32'h20080);
        run_op(0, 16'h80, 16'h01, 1'b1, got); check("w8_80_minus_1", got, 32'h3007F);
        run_op(0, 16'h05, 16'h05, 1'b1, got); check("w8_5_minus_5", got, 32'h50000);
        run_op(2, 16'h7FFF, 16'h0001, 1'b0, got); check("w16_n1_ovf", got, 32'h28000);
        run_op(2, 16'hFFFF, 16'h0001, 1'b0, got); check("w16_n1_wrap", got, 32'h50000);

        // Backpressure: results held, new operands ignored, no bypass on handshake edge.
        a = 16'h12; b = 16'h34; sub = 1'b0;
        in_valid[0] = 1'b1;
        cycle();
        in_valid[0] = 1'b0;
        wait_valid(0);
        in_valid[0] = 1'b1; a = 16'h55;
        for (int k = 0; k < 10; k++) begin
            cycle();
            check("bp_hold", res_of(0), 32'h46);
            check("bp_valid", 32'(out_valid[0]), 32'd1);
            check("bp_in_ready", 32'(in_ready[0]), 32'd0);
        end
        out_ready[0] = 1'b1;
        cycle();
        out_ready[0] = 1'b0;
        check("bp_rel_valid", 32'(out_valid[0]), 32'd0);
        check("bp_rel_in_ready", 32'(in_ready[0]), 32'd1);
        check("bp_rel_hold", res_of(0), 32'h46);
        in_valid[0] = 1'b0;

        // Reset two digits into a run aborts everything.
        a = 16'h21; b = 16'h43; sub = 1'b0;
        in_valid[0] = 1'b1;
        cycle();
        in_valid[0] = 1'b0;
        cycle(); cycle();
        check("mid_busy", 32'(in_ready[0]), 32'd0);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("mid_rst_result%0d", i), res_of(i), 32'd0);
            check($sformatf("mid_rst_valid%0d", i), 32'(out_valid[i]), 32'd0);
        end
        cycle();
        rst_n = 1'b1;
        cycle();
        check("mid_rel_in_ready", 32'(in_ready), 32'h7);
        run_op(0, 16'h33, 16'h44, 1'b0, got); check("post_rst_op", got, 32'h00077);

        // Random back-to-back traffic with random consumer stalls.
        ops = 0; guard = 0;
        while (ops < 1000 && guard < 20000) begin
            a   = 16'($urandom);
            b   = 16'($urandom);
            sub = 1'($urandom);
            for (int i = 0; i < 3; i++) begin
                in_valid[i]  = ($urandom % 4) != 0;
                out_ready[i] = ($urandom % 3) != 0;
                if (in_valid[i] && in_ready[i]) ops++;
            end
            cycle();
            guard++;
        end
        check("random_ops_done", 32'(ops >= 1000), 32'd1);
        in_valid = '0; out_ready = 3'h7;
        for (int k = 0; k < 10; k++) cycle();
        for (int i = 0; i < 3; i++) check($sformatf("drain%0d", i), 32'(pend[i]), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
